pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for wide operands. The operand is split into GROUP-bit lookahead groups, and each pipeline stage resolves GROUPS_PER_STAGE groups. The carry ripples between stages through registers. Valid/ready handshakes on both sides let the block sit between streaming datapath stages, with full backpressure and a throughput of one operation per cycle.

---
 rtl/pipelined_cla_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_cla_adder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Each stage resolves GROUPS_PER_STAGE lookahead groups; the carry moves between stages through registers.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned GROUP            = 4,
    parameter int unsigned GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned STAGE_W = GROUP * GROUPS_PER_STAGE;
    localparam int unsigned LAT     = WIDTH / STAGE_W;

    typedef struct packed {
        logic [STAGE_W-1:0] s;
        logic               c;
        logic               ovf;
    } slice_t;

    // One stage worth of lookahead groups; ovf is carry-into-top-bit xor carry-out.
    function automatic slice_t cla_slice(input logic [STAGE_W-1:0] x,
                                         input logic [STAGE_W-1:0] y,
                                         input logic               c_in);
        slice_t r;
        logic   c_grp, c_bit, g_grp, p_grp, gb, pb;
        r     = '0;
        c_grp = c_in;
        for (int unsigned j = 0; j < GROUPS_PER_STAGE; j++) begin
            g_grp = 1'b0;
            p_grp = 1'b1;
            c_bit = c_grp;
            for (int unsigned i = 0; i < GROUP; i++) begin
                gb                 = x[j*GROUP+i] & y[j*GROUP+i];
                pb                 = x[j*GROUP+i] | y[j*GROUP+i];
                r.s[j*GROUP+i]     = x[j*GROUP+i] ^ y[j*GROUP+i] ^ c_bit;
                r.ovf              = c_bit;
                c_bit              = gb | (pb & c_bit);
                g_grp              = gb | (pb & g_grp);
                p_grp              = p_grp & pb;
            end
            c_grp = g_grp | (p_grp & c_grp);
        end
        r.c   = c_grp;
        r.ovf = r.ovf ^ c_grp;
        return r;
    endfunction

    logic [WIDTH-1:0] a_q   [LAT];
    logic [WIDTH-1:0] b_q   [LAT];
    logic [WIDTH-1:0] sum_q [LAT];
    logic [WIDTH-1:0] a_d   [LAT];
    logic [WIDTH-1:0] b_d   [LAT];
    logic [WIDTH-1:0] sum_d [LAT];
    logic [LAT-1:0]   c_q, c_d, v_q, v_d;
    logic             ovf_q, ovf_d;
    slice_t           res [LAT];
    logic [WIDTH-1:0] b_eff;
    logic             adv;

    assign adv       = ~v_q[LAT-1] | out_ready;
    assign in_ready  = adv & ~rst;
    assign b_eff     = sub ? ~b : b;
    assign out_valid = v_q[LAT-1];
    assign sum       = sum_q[LAT-1];
    assign carry_out = c_q[LAT-1];
    assign overflow  = ovf_q;

    // Operand registers hold only not-yet-consumed bits, shifted down so each stage reads the low slice.
    always_comb begin
        res[0]                   = cla_slice(a[STAGE_W-1:0], b_eff[STAGE_W-1:0], sub | carry_in);
        a_d[0]                   = a >> STAGE_W;
        b_d[0]                   = b_eff >> STAGE_W;
        sum_d[0]                 = '0;
        sum_d[0][STAGE_W-1:0]    = res[0].s;
        c_d                      = '0;
        v_d                      = '0;
        c_d[0]                   = res[0].c;
        v_d[0]                   = in_valid & in_ready;
        for (int unsigned k = 1; k < LAT; k++) begin
            res[k]   = cla_slice(a_q[k-1][STAGE_W-1:0], b_q[k-1][STAGE_W-1:0], c_q[k-1]);
            a_d[k]   = a_q[k-1] >> STAGE_W;
            b_d[k]   = b_q[k-1] >> STAGE_W;
            sum_d[k] = sum_q[k-1];
            sum_d[k][k*STAGE_W +: STAGE_W] = res[k].s;
            c_d[k]   = res[k].c;
            v_d[k]   = v_q[k-1];
        end
        ovf_d = res[LAT-1].ovf;
    end

    // Whole pipeline, bubbles included, moves only on adv.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed table, throughput, backpressure, reset and random traffic.
module tb_pipelined_cla_adder;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, carry_in, sub, out_valid, out_ready, carry_out, overflow;
    logic [W-1:0] a, b, sum;

    logic         s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_cout, s_ovf;
    logic [7:0]   s_a, s_b, s_sum;

    pipelined_cla_adder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .carry_in(carry_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    pipelined_cla_adder #(.WIDTH(8), .GROUP(4), .GROUPS_PER_STAGE(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
        .carry_in(s_cin), .sub(s_sub), .out_valid(s_out_valid), .out_ready(1'b1),
        .sum(s_sum), .carry_out(s_cout), .overflow(s_ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  acc;
        bit           latchk;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W-1:0] s;
        logic         c, o;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    exp_t        sbq[$];
    exp_t        cur_exp, mon_e;
    bit          lat_chk, stalled, rnd_done;
    logic [W-1:0] hold_sum;
    logic         hold_c, hold_o;
    vec_t        tbl [9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operands as numbers.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        exp_t   r;
        longint sa, sb, sr, ua, ub, ur;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        if (msub) begin
            sr     = sa - sb;
            ur     = ua - ub;
            r.cout = (ua >= ub);
        end else begin
            sr     = sa + sb + longint'(mcin);
            ur     = ua + ub + longint'(mcin);
            r.cout = (ur > 64'sd4294967295);
        end
        r.sum    = ur[31:0];
        r.ovf    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.acc    = 0;
        r.latchk = 1'b0;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard, handshake rules and stall stability, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            stalled = 1'b0;
            check("in_ready_in_reset", 64'(in_ready), 64'(0));
        end else begin
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_hold", 64'({sum, carry_out, overflow}), 64'({hold_sum, hold_c, hold_o}));
            end
            if (in_valid && in_ready) begin
                mon_e        = cur_exp;
                mon_e.acc    = cyc;
                mon_e.latchk = lat_chk;
                sbq.push_back(mon_e);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out actual=%h required=no_result", sum);
                end else begin
                    mon_e = sbq.pop_front();
                    check("result", 64'({sum, carry_out, overflow}), 64'({mon_e.sum, mon_e.cout, mon_e.ovf}));
                    if (mon_e.latchk) check("latency", 64'(cyc - mon_e.acc), 64'(LAT));
                end
            end
            stalled  = out_valid && !out_ready;
            hold_sum = sum;
            hold_c   = carry_out;
            hold_o   = overflow;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                         input logic tsub, input exp_t e);
        bit acc;
        int n;
        a = ta; b = tb_; carry_in = tcin; sub = tsub; in_valid = 1'b1;
        cur_exp = e;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic send_model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                              input logic tcin, input logic tsub);
        drive(ta, tb_, tcin, tsub, model(ta, tb_, tcin, tsub));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sbq.size());
        end
    endtask

    task automatic small_vec(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                             input logic tsub, input logic [7:0] es, input logic ec, input logic eo);
        s_a = ta; s_b = tb_; s_cin = tcin; s_sub = tsub; s_in_valid = 1'b1;
        @(negedge clk);
        check("small_in_ready", 64'(s_in_ready), 64'(1));
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("small_early", 64'(s_out_valid), 64'(0));
        @(negedge clk);
        check("small_valid", 64'(s_out_valid), 64'(1));
        check("small_result", 64'({s_sum, s_cout, s_ovf}), 64'({es, ec, eo}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[5] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        tbl[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
        out_ready = 1'b1; lat_chk = 1'b1; rnd_done = 1'b0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
        cur_exp = model('0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", 64'({sum, carry_out, overflow}), 64'(0));
        check("rst_small_valid", 64'(s_out_valid), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, one at a time, exact latency.
        for (int i = 0; i < 9; i++) begin
            cur_exp.sum  = tbl[i].s;
            cur_exp.cout = tbl[i].c;
            cur_exp.ovf  = tbl[i].o;
            drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, cur_exp);
            idle(0);
            wait_drain(20);
        end

        // Back-to-back throughput.
        for (int i = 0; i < 8; i++) send_model(32'(i), 32'(i) * 32'h1111_1111, 1'b0, 1'b0);
        idle(0);
        wait_drain(20);

        // Backpressure: fill, stall five cycles with a beat waiting, release.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_model(rnd_op(), rnd_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
        fork
            begin
                send_model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
                send_model(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1);
                idle(0);
            end
            begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                check("bp_no_accept", 64'(sbq.size()), 64'(4));
                out_ready = 1'b1;
            end
        join
        wait_drain(30);

        // Random traffic with random gaps and backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) idle(1);
                    send_model(rnd_op(), rnd_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
                idle(0);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(9) < 7);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(100);

        // Reset mid-flight: in-flight beats vanish, then normal latency resumes.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) send_model(32'(i + 100), 32'h0000_0001, 1'b0, 1'b0);
        idle(0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_outputs", 64'({sum, carry_out, overflow}), 64'(0));
        @(posedge clk);
        #1;
        idle(6);
        send_model(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        idle(0);
        wait_drain(20);

        // Narrow instance: two-stage latency, boundary carry and overflow.
        small_vec(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        small_vec(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        small_vec(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        small_vec(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        small_vec(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
